// File: rtl/condition_if.sv
// condition_if: start/operand/result signals between a requester and condition_unit
// master: drives con_in, cond, bus_in, b_valid, cancel; receives con_out, done, busy
// slave:  the condition_unit side of the same signals
interface condition_if #(parameter int WIDTH = 32);
  logic             con_in;
  logic [3:0]       cond;
  logic [WIDTH-1:0] bus_in;
  logic             b_valid;
  logic             cancel;
  logic             con_out;
  logic             done;
  logic             busy;
  modport master(output con_in, cond, bus_in, b_valid, cancel, input con_out, done, busy);
  modport slave(input con_in, cond, bus_in, b_valid, cancel, output con_out, done, busy);
endinterface

// File: rtl/condition_unit.sv
// condition_unit: evaluates a condition code on one operand (vs zero) or two operands from a shared bus
// clock/clear: rising-edge clock, synchronous active-high clear
// cu (slave):  con_in/cond/bus_in start, b_valid supplies operand B, cancel aborts,
//              con_out registered result, done one-cycle completion pulse, busy while waiting for B
module condition_unit #(
  parameter int   WIDTH    = 32,
  parameter logic CON_INIT = 1'b0
) (
  input logic         clock,
  input logic         clear,
  condition_if.slave  cu
);
  typedef enum logic {IDLE, WAIT_B} state_t;
  state_t           state_q, state_d;
  logic             con_q, con_d, done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [3:0]       cond_q, cond_d;
  // single-operand codes reuse the two-operand table with b = 0; slots 6/7 become ALWAYS/NEVER
  function automatic logic eval(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic       eq, lt, ltu;
    logic [7:0] t;
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    t   = {c[3] ? ltu : 1'b0, c[3] ? ~ltu : 1'b1, lt | eq, ~(lt | eq), lt, ~lt, ~eq, eq};
    return t[c[2:0]];
  endfunction
  always_comb begin
    state_d = state_q;
    con_d   = con_q;
    done_d  = 1'b0;
    a_d     = a_q;
    cond_d  = cond_q;
    if (state_q == IDLE && cu.con_in) begin
      if (cu.cond[3]) begin
        state_d = WAIT_B;
        a_d     = cu.bus_in;
        cond_d  = cu.cond;
      end else begin
        con_d  = eval(cu.cond, cu.bus_in, '0);
        done_d = 1'b1;
      end
    end else if (state_q == WAIT_B && cu.cancel) begin
      state_d = IDLE;
    end else if (state_q == WAIT_B && cu.b_valid) begin
      con_d   = eval(cond_q, a_q, cu.bus_in);
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      con_q   <= CON_INIT;
      done_q  <= 1'b0;
      a_q     <= '0;
      cond_q  <= '0;
    end else begin
      state_q <= state_d;
      con_q   <= con_d;
      done_q  <= done_d;
      a_q     <= a_d;
      cond_q  <= cond_d;
    end
  end
  assign cu.con_out = con_q;
  assign cu.done    = done_q;
  assign cu.busy    = (state_q == WAIT_B);
endmodule
